// File: rtl/inst_text_writer.sv
// Streams a fixed-width ASCII string into the VGA character RAM, one character per cycle.
// Leading NULs become spaces, off-screen characters are clipped, and unchanged repeats are skipped.
module inst_text_writer #(
   parameter int unsigned NCHAR  = 19,
   parameter int unsigned COLS   = 80,
   parameter int unsigned ADDR_W = 12
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NCHAR*8-1:0]   inst_i,
   input  logic [4:0]           row_i,
   input  logic [6:0]           col_i,
   input  logic                 force_i,
   input  logic                 start_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 wr_en_o,
   output logic [ADDR_W-1:0]    wr_addr_o,
   output logic [7:0]           wr_data_o
);

   localparam int unsigned STR_W = NCHAR * 8;
   localparam int unsigned IDX_W = $clog2(NCHAR);
   localparam int unsigned LAST  = NCHAR - 1;
   localparam int unsigned AW    = (ADDR_W + 1 > 13) ? ADDR_W + 1 : 13;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [STR_W-1:0]   str_q, str_d;
   logic [4:0]         row_q, row_d;
   logic [6:0]         col_q, col_d;
   logic               last_valid_q, last_valid_d;
   logic [STR_W-1:0]   last_str_q, last_str_d;
   logic [4:0]         last_row_q, last_row_d;
   logic [6:0]         last_col_q, last_col_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [7:0]         wr_data_q, wr_data_d;

   logic [7:0]         ch;
   logic               in_range;
   logic               skip;

   // Next-state and registered-output decode; outputs lag the state by one edge.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      str_d        = str_q;
      row_d        = row_q;
      col_d        = col_q;
      last_valid_d = last_valid_q;
      last_str_d   = last_str_q;
      last_row_d   = last_row_q;
      last_col_d   = last_col_q;
      busy_d       = (state_q != S_IDLE);
      done_d       = 1'b0;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;

      ch       = 8'(str_q >> ((LAST - 32'(idx_q)) * 32'd8));
      in_range = (32'(col_q) + 32'(idx_q)) < COLS;
      skip     = last_valid_q && !force_i && (inst_i == last_str_q) &&
                 (row_i == last_row_q) && (col_i == last_col_q);

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               str_d   = inst_i;
               row_d   = row_i;
               col_d   = col_i;
               idx_d   = '0;
               state_d = skip ? S_DONE : S_WRITE;
            end
         end
         S_WRITE: begin
            wr_en_d   = in_range;
            wr_addr_d = ADDR_W'(AW'(row_q) * AW'(COLS) + AW'(col_q) + AW'(idx_q));
            wr_data_d = (ch == 8'h00) ? 8'h20 : ch;
            if (idx_q == IDX_W'(LAST)) begin
               state_d      = S_DONE;
               last_valid_d = 1'b1;
               last_str_d   = str_q;
               last_row_d   = row_q;
               last_col_d   = col_q;
            end else begin
               idx_d = IDX_W'(idx_q + 1'b1);
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         str_q        <= '0;
         row_q        <= '0;
         col_q        <= '0;
         last_valid_q <= 1'b0;
         last_str_q   <= '0;
         last_row_q   <= '0;
         last_col_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         str_q        <= str_d;
         row_q        <= row_d;
         col_q        <= col_d;
         last_valid_q <= last_valid_d;
         last_str_q   <= last_str_d;
         last_row_q   <= last_row_d;
         last_col_q   <= last_col_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign wr_en_o   = wr_en_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_inst_text_writer.sv
// Randomized self-checking bench for inst_text_writer against a per-cycle screen-write model.
module tb_inst_text_writer;

   localparam int NCHAR  = 19;
   localparam int COLS   = 80;
   localparam int ADDR_W = 12;

   logic                 clk;
   logic                 rst;
   logic [NCHAR*8-1:0]   inst;
   logic [4:0]           row;
   logic [6:0]           col;
   logic                 frc;
   logic                 start;
   logic                 busy;
   logic                 done;
   logic                 wr_en;
   logic [ADDR_W-1:0]    wr_addr;
   logic [7:0]           wr_data;

   inst_text_writer #(.NCHAR(NCHAR), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .inst_i    (inst),
      .row_i     (row),
      .col_i     (col),
      .force_i   (frc),
      .start_i   (start),
      .busy_o    (busy),
      .done_o    (done),
      .wr_en_o   (wr_en),
      .wr_addr_o (wr_addr),
      .wr_data_o (wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model memory of the last fully written request.
   bit                 m_valid = 1'b0;
   logic [NCHAR*8-1:0] m_str;
   int                 m_row;
   int                 m_col;

   // Expected and observed per-cycle traces, index k = cycles after acceptance.
   int          e_n;
   bit          e_en   [0:31];
   bit          e_done [0:31];
   bit          e_busy [0:31];
   int          e_addr [0:31];
   logic [7:0]  e_data [0:31];
   logic        o_en   [0:31];
   logic        o_done [0:31];
   logic        o_busy [0:31];
   logic [11:0] o_addr [0:31];
   logic [7:0]  o_data [0:31];

   function automatic logic [NCHAR*8-1:0] rand_str();
      logic [NCHAR*8-1:0] s;
      for (int i = 0; i < NCHAR; i++) s[i*8 +: 8] = 8'($urandom_range(0, 127));
      return s;
   endfunction

   // Screen-level view: which cells get which glyphs, and when the request finishes.
   task automatic model_req(input logic [NCHAR*8-1:0] s, input int r, input int c, input bit f);
      logic [7:0] glyph [NCHAR];
      bit skip;
      skip = m_valid && !f && (s == m_str) && (r == m_row) && (c == m_col);
      for (int i = 0; i < NCHAR; i++) begin
         glyph[i] = s[(NCHAR - i) * 8 - 1 -: 8];
         if (glyph[i] == 8'h00) glyph[i] = 8'h20;
      end
      for (int k = 0; k < 32; k++) begin
         e_en[k] = 0; e_done[k] = 0; e_busy[k] = 0; e_addr[k] = 0; e_data[k] = 0;
      end
      if (skip) begin
         e_n = 2;
         e_done[1] = 1; e_busy[1] = 1;
      end else begin
         e_n = NCHAR + 2;
         for (int i = 0; i < NCHAR; i++) begin
            e_en[i+1]   = (c + i) < COLS;
            e_addr[i+1] = (r * COLS + c + i) % 4096;
            e_data[i+1] = glyph[i];
            e_busy[i+1] = 1;
         end
         e_done[NCHAR+1] = 1; e_busy[NCHAR+1] = 1;
         m_valid = 1; m_str = s; m_row = r; m_col = c;
      end
   endtask

   task automatic issue(input logic [NCHAR*8-1:0] s, input int r, input int c, input bit f);
      inst = s; row = 5'(r); col = 7'(c); frc = f; start = 1'b1;
      model_req(s, r, c, f);
   endtask

   // Accepting edge, then n samples taken on the falling edge after each following rising edge.
   task automatic capture(input int n, input bit hold);
      @(posedge clk);
      @(negedge clk);
      if (!hold) begin
         start = 1'b0; inst = rand_str(); row = 5'($urandom); col = 7'($urandom); frc = 1'($urandom);
      end
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         o_en[k] = wr_en; o_done[k] = done; o_busy[k] = busy; o_addr[k] = wr_addr; o_data[k] = wr_data;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; frc = 1'b0; inst = '0; row = '0; col = '0;
      repeat (3) @(negedge clk);
      n_cmp += 5;
      if (busy !== 1'b0)     begin n_err++; $display("FAIL reset busy got %b exp 0", busy); end
      if (done !== 1'b0)     begin n_err++; $display("FAIL reset done got %b exp 0", done); end
      if (wr_en !== 1'b0)    begin n_err++; $display("FAIL reset wr_en got %b exp 0", wr_en); end
      if (wr_addr !== 12'd0) begin n_err++; $display("FAIL reset wr_addr got %0d exp 0", wr_addr); end
      if (wr_data !== 8'd0)  begin n_err++; $display("FAIL reset wr_data got %h exp 00", wr_data); end
      rst = 1'b0;
      m_valid = 0;
   endtask

   task automatic test_write();
      logic [NCHAR*8-1:0] s;
      for (int t = 0; t < 8; t++) begin
         if (t == 0)      begin s = "nop JStall:addi0   "; issue(s, 2, 0, 1'b0); end
         else if (t == 1) begin s = "not in use";          issue(s, 0, 0, 1'b0); end
         else issue(rand_str(), $urandom_range(0, 31), $urandom_range(0, 60), 1'($urandom));
         capture(e_n, 1'b0);
         for (int k = 1; k <= e_n; k++) begin
            n_cmp += 3;
            if (o_en[k] !== e_en[k])     begin n_err++; $display("FAIL write t=%0d k=%0d wr_en got %b exp %b", t, k, o_en[k], e_en[k]); end
            if (o_done[k] !== e_done[k]) begin n_err++; $display("FAIL write t=%0d k=%0d done got %b exp %b", t, k, o_done[k], e_done[k]); end
            if (o_busy[k] !== e_busy[k]) begin n_err++; $display("FAIL write t=%0d k=%0d busy got %b exp %b", t, k, o_busy[k], e_busy[k]); end
            if (e_en[k]) begin
               n_cmp += 2;
               if (o_addr[k] !== 12'(e_addr[k])) begin n_err++; $display("FAIL write t=%0d k=%0d wr_addr got %0d exp %0d", t, k, o_addr[k], e_addr[k]); end
               if (o_data[k] !== e_data[k])      begin n_err++; $display("FAIL write t=%0d k=%0d wr_data got %h exp %h", t, k, o_data[k], e_data[k]); end
            end
         end
      end
   endtask

   task automatic test_skip();
      logic [NCHAR*8-1:0] s;
      bit f [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      int c [4] = '{7, 7, 7, 8};
      s = rand_str();
      issue(s, 3, 7, 1'b1);
      capture(e_n, 1'b0);
      for (int t = 0; t < 4; t++) begin
         issue(s, 3, c[t], f[t]);
         capture(e_n, 1'b0);
         for (int k = 1; k <= e_n; k++) begin
            n_cmp += 3;
            if (o_en[k] !== e_en[k])     begin n_err++; $display("FAIL skip t=%0d k=%0d wr_en got %b exp %b", t, k, o_en[k], e_en[k]); end
            if (o_done[k] !== e_done[k]) begin n_err++; $display("FAIL skip t=%0d k=%0d done got %b exp %b", t, k, o_done[k], e_done[k]); end
            if (o_busy[k] !== e_busy[k]) begin n_err++; $display("FAIL skip t=%0d k=%0d busy got %b exp %b", t, k, o_busy[k], e_busy[k]); end
            if (e_en[k]) begin
               n_cmp += 2;
               if (o_addr[k] !== 12'(e_addr[k])) begin n_err++; $display("FAIL skip t=%0d k=%0d wr_addr got %0d exp %0d", t, k, o_addr[k], e_addr[k]); end
               if (o_data[k] !== e_data[k])      begin n_err++; $display("FAIL skip t=%0d k=%0d wr_data got %h exp %h", t, k, o_data[k], e_data[k]); end
            end
         end
      end
   endtask

   task automatic test_clip();
      int r [6] = '{1, 31, 0, 17, 31, 5};
      int c [6] = '{70, 79, 127, 61, 100, 80};
      for (int t = 0; t < 6; t++) begin
         issue(rand_str(), r[t], c[t], 1'b1);
         capture(e_n, 1'b0);
         for (int k = 1; k <= e_n; k++) begin
            n_cmp += 3;
            if (o_en[k] !== e_en[k])     begin n_err++; $display("FAIL clip t=%0d k=%0d wr_en got %b exp %b", t, k, o_en[k], e_en[k]); end
            if (o_done[k] !== e_done[k]) begin n_err++; $display("FAIL clip t=%0d k=%0d done got %b exp %b", t, k, o_done[k], e_done[k]); end
            if (o_busy[k] !== e_busy[k]) begin n_err++; $display("FAIL clip t=%0d k=%0d busy got %b exp %b", t, k, o_busy[k], e_busy[k]); end
            if (e_en[k]) begin
               n_cmp += 2;
               if (o_addr[k] !== 12'(e_addr[k])) begin n_err++; $display("FAIL clip t=%0d k=%0d wr_addr got %0d exp %0d", t, k, o_addr[k], e_addr[k]); end
               if (o_data[k] !== e_data[k])      begin n_err++; $display("FAIL clip t=%0d k=%0d wr_data got %h exp %h", t, k, o_data[k], e_data[k]); end
            end
         end
      end
   endtask

   // start held high: ignored while busy, re-triggers the moment IDLE is reached.
   task automatic test_back_to_back();
      logic [NCHAR*8-1:0] s;
      int len;
      s = rand_str();
      for (int t = 0; t < 4; t++) begin
         if (t == 0)      issue(rand_str(), 4, 10, 1'b1);
         else if (t == 1) issue(s, 6, 2, 1'b1);
         else             issue(s, 6, 2, 1'b0);
         len = (t == 3) ? e_n : e_n - 1;
         capture(len, 1'b1);
         if (t == 3) start = 1'b0;
         for (int k = 1; k <= len; k++) begin
            n_cmp += 3;
            if (o_en[k] !== e_en[k])     begin n_err++; $display("FAIL b2b t=%0d k=%0d wr_en got %b exp %b", t, k, o_en[k], e_en[k]); end
            if (o_done[k] !== e_done[k]) begin n_err++; $display("FAIL b2b t=%0d k=%0d done got %b exp %b", t, k, o_done[k], e_done[k]); end
            if (o_busy[k] !== e_busy[k]) begin n_err++; $display("FAIL b2b t=%0d k=%0d busy got %b exp %b", t, k, o_busy[k], e_busy[k]); end
            if (e_en[k]) begin
               n_cmp += 2;
               if (o_addr[k] !== 12'(e_addr[k])) begin n_err++; $display("FAIL b2b t=%0d k=%0d wr_addr got %0d exp %0d", t, k, o_addr[k], e_addr[k]); end
               if (o_data[k] !== e_data[k])      begin n_err++; $display("FAIL b2b t=%0d k=%0d wr_data got %h exp %h", t, k, o_data[k], e_data[k]); end
            end
         end
         if (t == 3) @(negedge clk);
      end
   endtask

   task automatic test_reset_abort();
      logic [NCHAR*8-1:0] s;
      s = rand_str();
      issue(s, 9, 20, 1'b1);
      capture(8, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         n_cmp += 2;
         if (o_en[k] !== e_en[k])            begin n_err++; $display("FAIL abort k=%0d wr_en got %b exp %b", k, o_en[k], e_en[k]); end
         if (o_addr[k] !== 12'(e_addr[k]))   begin n_err++; $display("FAIL abort k=%0d wr_addr got %0d exp %0d", k, o_addr[k], e_addr[k]); end
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp += 5;
      if (busy !== 1'b0)     begin n_err++; $display("FAIL abort busy got %b exp 0", busy); end
      if (done !== 1'b0)     begin n_err++; $display("FAIL abort done got %b exp 0", done); end
      if (wr_en !== 1'b0)    begin n_err++; $display("FAIL abort wr_en got %b exp 0", wr_en); end
      if (wr_addr !== 12'd0) begin n_err++; $display("FAIL abort wr_addr got %0d exp 0", wr_addr); end
      if (wr_data !== 8'd0)  begin n_err++; $display("FAIL abort wr_data got %h exp 00", wr_data); end
      rst = 1'b0;
      m_valid = 0;
      // An identical request now must write in full; then a repeat of it must skip.
      for (int t = 0; t < 2; t++) begin
         issue(s, 9, 20, 1'b0);
         capture(e_n, 1'b0);
         for (int k = 1; k <= e_n; k++) begin
            n_cmp += 3;
            if (o_en[k] !== e_en[k])     begin n_err++; $display("FAIL rewrite t=%0d k=%0d wr_en got %b exp %b", t, k, o_en[k], e_en[k]); end
            if (o_done[k] !== e_done[k]) begin n_err++; $display("FAIL rewrite t=%0d k=%0d done got %b exp %b", t, k, o_done[k], e_done[k]); end
            if (o_busy[k] !== e_busy[k]) begin n_err++; $display("FAIL rewrite t=%0d k=%0d busy got %b exp %b", t, k, o_busy[k], e_busy[k]); end
            if (e_en[k]) begin
               n_cmp += 2;
               if (o_addr[k] !== 12'(e_addr[k])) begin n_err++; $display("FAIL rewrite t=%0d k=%0d wr_addr got %0d exp %0d", t, k, o_addr[k], e_addr[k]); end
               if (o_data[k] !== e_data[k])      begin n_err++; $display("FAIL rewrite t=%0d k=%0d wr_data got %h exp %h", t, k, o_data[k], e_data[k]); end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_skip();
      test_clip();
      test_back_to_back();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/inst_text_writer.md
# inst_text_writer

Downstream consumer of the instruction-disassembly string in the debug display path. Accepts a fixed-width ASCII string (19 characters, MSB byte first) plus a screen position, then writes one character per cycle into the VGA character RAM. Leading zero bytes are written as spaces, and characters past the right screen edge are clipped. Unchanged strings at an unchanged position are skipped to reduce RAM write traffic.

## Interface
- NCHAR, 19, characters per string
- COLS, 80, characters per screen row
- ADDR_W, 12, character-RAM address width

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- inst  in  NCHAR*8  ASCII string; char i = inst[(NCHAR-i)*8-1 -: 8], i=0 leftmost
- row  in  5  target screen row
- col  in  7  starting screen column
- force  in  1  sampled with start; 1 disables the skip check
- start  in  1  request; accepted only in IDLE
- busy  out  1  high in WRITE and DONE states
- done  out  1  one-cycle pulse ending each accepted request
- wr_en  out  1  character-RAM write strobe
- wr_addr  out  ADDR_W  character-RAM address
- wr_data  out  8  character code

## Operation
- Reset values: busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0. State=IDLE, idx=0, last_valid=0.
- States:
  - IDLE: on start, latch inst, row, col into str_q, row_q, col_q. Go to WRITE, or go to DONE directly if skipping.
  - WRITE: runs exactly NCHAR cycles.
  - DONE: lasts one cycle, then IDLE.
- Skip condition at acceptance: last_valid=1, force=0, inst==last_str, row==last_row, col==last_col.
- In each WRITE cycle for idx 0..NCHAR-1, the registered outputs are:
  - wr_addr = (row_q*COLS + col_q + idx) truncated to ADDR_W.
  - wr_data = char idx of str_q, with 0x00 mapped to 0x20. All other bytes pass unchanged.
  - wr_en = 1 iff col_q+idx < COLS. Clipped characters still consume their cycle (fixed latency), with wr_en=0.
- Address arithmetic is done at ≥ ADDR_W+1 bits, then truncated. row_q*COLS is computed at ≥ 12 bits.
- On entering DONE from WRITE, update last_str/last_row/last_col from the latched values and set last_valid=1. The skip path leaves them unchanged.
- start while busy=1 is ignored (not queued). start is level-sampled only in IDLE, so start held high re-triggers every time IDLE is reached.
- rst mid-operation aborts immediately: no further writes, outputs return to reset values next edge, last_valid cleared.
- inst/row/col may change freely after acceptance; only latched copies are used.

## Timing
- start sampled high in IDLE at edge T:
  - Write path: wr_en/wr_addr/wr_data valid for edges T+1..T+NCHAR, done=1 at T+NCHAR+1.
  - busy=1 from T+1 through T+NCHAR+1. Next start can be accepted at edge T+NCHAR+2.
- Skip path: done=1 and busy=1 at T+1 only, with no wr_en. Next start accepted at T+2.
- Back-to-back requests therefore cost NCHAR+2 cycles (write) or 2 cycles (skip).
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then start with inst="nop JStall:addi0   ", row=2, col=0:
  - 19 writes at addresses 160..178, data 0x6E,0x6F,0x70,0x20,….
  - done at cycle 20, busy low at cycle 21.
- inst="not in use" (9 leading 0x00 bytes), row=0, col=0:
  - addresses 0..8 receive 0x20, addresses 9..18 receive "not in use".
- Same inst/row/col repeated, force=0: done one cycle after start, zero wr_en pulses. Repeat with force=1: full 19 writes.
- col=70, row=1: writes only to addresses 150..159 (10 chars). Cycles for idx 10..18 have wr_en=0, and done still arrives at cycle 20.
- Second start pulse issued at cycle 5 of a write: ignored, with exactly 19 write cycles and one done pulse. Assert rst at write cycle 8: wr_en=0 next edge, all outputs at reset values. A following identical request performs the full write (last_valid cleared).
- row=31, col=79 (address 2559): verify no truncation error at 12 bits, and write only at idx 0 (others clipped).
